// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one SRAM controller between two word requesters.
// Optional WAIT watchdog (err flag, 32'hDEADBEEF read data) enabled by defining SRAM_ARB_WDOG_EN.
module sram_arbiter #(
    parameter int WDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_stall,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic        grant,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state;
    logic        last;
    logic        we_l;
    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rd_val;
    logic        timeout;
    // on a tie the port that was not served last wins
    assign pick      = m1_req & (~m0_req | ~last);
    assign sel_we    = pick ? m1_we : m0_we;
    assign sel_addr  = pick ? m1_addr : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;
    assign rd_val    = timeout ? 32'hDEAD_BEEF : mem_read_data;
    assign busy      = state != IDLE;
    assign m0_stall  = m0_req & ~m0_done;
    assign m1_stall  = m1_req & ~m1_done;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last           <= 1'b1;
            we_l           <= 1'b0;
            mem_wr_en      <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
            m0_done        <= 1'b0;
            m1_done        <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: if (m0_req | m1_req) begin
                    state          <= ISSUE;
                    grant          <= pick;
                    we_l           <= sel_we;
                    mem_address    <= sel_addr;
                    mem_write_data <= sel_wdata;
                    mem_wr_en      <= sel_we;
                    mem_rd_en      <= ~sel_we;
                end
                ISSUE: begin
                    state     <= WAIT;
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                end
                WAIT: if (mem_ready | timeout) begin
                    state   <= RESP;
                    m0_done <= ~grant;
                    m1_done <= grant;
                    if (!we_l && !grant) m0_rdata <= rd_val;
                    if (!we_l && grant) m1_rdata <= rd_val;
                end
                RESP: begin
                    state <= IDLE;
                    last  <= grant;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SRAM_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES) + 1;
    localparam logic [CW-1:0] WLAST = CW'(WDOG_CYCLES - 1);
    logic [CW-1:0] wcnt;
    // wcnt holds the number of completed WAIT cycles; it is zero on WAIT entry
    assign timeout = (state == WAIT) && !mem_ready && (wcnt == WLAST);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (timeout) err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table plus scoreboard for sram_arbiter, with a latency-programmable controller model.
module tb_sram_arbiter;
`ifdef SRAM_ARB_WDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 64;
`endif
    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    typedef struct {
        bit          port;
        logic [31:0] r0;
        logic [31:0] r1;
    } exp_t;

    logic        clk = 0, rst = 0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [31:0] m0_rdata, m1_rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 0;
    logic        m0_done, m0_stall, m1_done, m1_stall;
    logic        mem_wr_en, mem_rd_en, grant, busy, err;
    logic        model_ready = 0, spur_ready = 0;
    int          lat = 1;
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, m1_cnt = 0;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] exp_r [2];
    exp_t        sb [$];
    vec_t        tbl [6];

    sram_arbiter #(.WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_stall(m1_stall),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_ready(model_ready | spur_ready),
        .grant(grant), .busy(busy), .err(err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (m1_done) m1_cnt <= m1_cnt + 1;
    end

    // controller model: ready is high in the lat-th cycle after the ISSUE cycle; lat=0 never answers
    initial forever begin
        int l;
        @(posedge clk); #1;
        if (mem_wr_en || mem_rd_en) begin
            if (mem_wr_en) smem[mem_address] = mem_write_data;
            mem_read_data = smem.exists(mem_address) ? smem[mem_address] : 32'h0;
            l = lat;
            if (l > 0) begin
                repeat (l) @(posedge clk);
                #1 model_ready = 1;
                @(posedge clk);
                #1 model_ready = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit p, bit w, logic [31:0] a, logic [31:0] d, int l, logic [31:0] r, int el);
        vec_t v;
        v.port = p; v.we = w; v.addr = a; v.wdata = d; v.lat = l; v.exp_rdata = r; v.exp_lat = el;
        return v;
    endfunction

    task automatic sb_push(input bit p, input bit w, input logic [31:0] r);
        exp_t e;
        if (!w) exp_r[p] = r;
        e.port = p; e.r0 = exp_r[0]; e.r1 = exp_r[1];
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_single_done"}, {31'b0, m0_done & m1_done}, 32'h0);
        chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_done_port"}, {31'b0, m1_done}, {31'b0, e.port});
            chk({tag, "_m0_rdata"}, m0_rdata, e.r0);
            chk({tag, "_m1_rdata"}, m1_rdata, e.r1);
        end
    endtask

    task automatic drive(input bit p, input logic r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
        else begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int  k = 0, d = 0, w0, r0;
        bit  seen = 0, stable = 1;
        lat = v.lat;
        sb_push(v.port, v.we, v.exp_rdata);
        @(posedge clk); #1;
        w0 = wr_cnt; r0 = rd_cnt;
        drive(v.port, 1, v.we, v.addr, v.wdata);
        k = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy && (mem_address !== v.addr || mem_write_data !== v.wdata || grant !== v.port)) stable = 0;
            if (v.port ? m1_done : m0_done) begin
                seen = 1;
                d = cyc;
                sb_check(tag);
                drive(v.port, 0, v.we, v.addr, v.wdata);
            end
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'h1);
        chk({tag, "_latency"}, 32'(d - k + 1), 32'(v.exp_lat));
        chk({tag, "_bus_stable"}, {31'b0, stable}, 32'h1);
        @(posedge clk); #1;
        chk({tag, "_stall_after"}, {31'b0, v.port ? m1_stall : m0_stall}, 32'h0);
        chk({tag, "_idle_after"}, {31'b0, busy}, 32'h0);
        chk({tag, "_wr_pulses"}, 32'(wr_cnt - w0), v.we ? 32'h1 : 32'h0);
        chk({tag, "_rd_pulses"}, 32'(rd_cnt - r0), v.we ? 32'h0 : 32'h1);
    endtask

    task automatic run_both(input int n0, input int n1, input logic [3:0] exp_ord, input string tag);
        int c0 = 0, c1 = 0, viol = 0;
        logic [3:0] ord = '0;
        bit fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk); #1;
            if (busy && (grant ? (m0_req && !m0_stall) : (m1_req && !m1_stall))) viol++;
            if (m0_done || m1_done) begin
                sb_check(tag);
                ord = {ord[2:0], m1_done};
                if (m0_done) c0++;
                if (m1_done) c1++;
                if (m0_done && c0 == n0) m0_req = 0;
                if (m1_done && c1 == n1) m1_req = 0;
            end
            fin = (c0 == n0) && (c1 == n1);
        end
        chk({tag, "_all_done"}, {31'b0, fin}, 32'h1);
        chk({tag, "_grant_order"}, {28'b0, ord}, {28'b0, exp_ord});
        chk({tag, "_loser_stall"}, 32'(viol), 32'h0);
    endtask

    initial begin
        int c1;
        exp_r[0] = 0; exp_r[1] = 0;
        tbl[0] = mk(0, 1, 32'h10, 32'hCAFE_1234, 4, 32'h0, 7);
        tbl[1] = mk(1, 0, 32'h10, 32'h0, 2, 32'hCAFE_1234, 5);
        tbl[2] = mk(1, 1, 32'h20, 32'h1111_2222, 1, 32'h0, 4);
        tbl[3] = mk(0, 0, 32'h20, 32'h0, 3, 32'h1111_2222, 6);
        tbl[4] = mk(0, 0, 32'h10, 32'h0, 1, 32'hCAFE_1234, 4);
        tbl[5] = mk(1, 0, 32'h20, 32'h0, 6, 32'h1111_2222, 9);
        #2;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_grant", {31'b0, grant}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_en", {30'b0, mem_wr_en, mem_rd_en}, 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_done", {30'b0, m0_done, m1_done}, 32'h0);
        #21 rst = 1;
        foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

        lat = 2;
        @(posedge clk); #1;
        drive(0, 1, 0, 32'h10, 32'h0);
        drive(1, 1, 0, 32'h20, 32'h0);
        sb_push(0, 0, 32'hCAFE_1234);
        sb_push(1, 0, 32'h1111_2222);
        sb_push(0, 0, 32'hCAFE_1234);
        sb_push(1, 0, 32'h1111_2222);
        run_both(2, 2, 4'b0101, "rr4");

        @(posedge clk); #1 spur_ready = 1;
        @(posedge clk); #1 spur_ready = 0;
        chk("spur_idle", {31'b0, busy}, 32'h0);
        c1 = wr_cnt + rd_cnt;
        do_txn(mk(0, 0, 32'h20, 32'h0, 3, 32'h1111_2222, 6), "spur");
        chk("spur_done_cnt", 32'(sb.size()), 32'h0);

        lat = 0;
        @(posedge clk); #1;
        drive(1, 1, 0, 32'h10, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        chk("arst_pre_busy", {31'b0, busy}, 32'h1);
        c1 = m1_cnt;
        #3 rst = 0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_en", {30'b0, mem_wr_en, mem_rd_en}, 32'h0);
        chk("arst_addr", mem_address, 32'h0);
        chk("arst_rdata", {m0_rdata | m1_rdata}, 32'h0);
        chk("arst_done", {30'b0, m0_done, m1_done}, 32'h0);
        m1_req = 0;
        exp_r[0] = 0; exp_r[1] = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        repeat (3) @(posedge clk);
        #1 chk("arst_no_m1_done", 32'(m1_cnt - c1), 32'h0);

        lat = 1;
        drive(0, 1, 1, 32'h30, 32'h5555_AAAA);
        drive(1, 1, 0, 32'h30, 32'h0);
        sb_push(0, 1, 32'h0);
        sb_push(1, 0, 32'h5555_AAAA);
        run_both(1, 1, 4'b0001, "post_rst");

`ifdef SRAM_ARB_WDOG_EN
        do_txn(mk(0, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 3 + WD), "wdog");
        chk("wdog_err_set", {31'b0, err}, 32'h1);
        do_txn(mk(1, 0, 32'h30, 32'h0, 2, 32'h5555_AAAA, 5), "wdog_after");
        chk("wdog_err_sticky", {31'b0, err}, 32'h1);
`else
        chk("err_tied_low", {31'b0, err}, 32'h0);
`endif
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two 32-bit word requesters:
  - port 0: MEM-stage data access.
  - port 1: secondary master, e.g. loader or debug.
- Latches each request, drives the controller's wr_en/rd_en/address/write_data and holds them stable for the whole transaction.
- Waits for the controller's ready pulse, returns read data to the granted port, and stalls requesters that are not yet served.
- Sits between the pipeline memory stage and the SRAM controller.

Parameters:
- WDOG_CYCLES, 64, cycles in WAIT before watchdog abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset; the block is in reset while rst=0
- m0_req  input  1  port 0 request, held high until m0_done
- m0_we  input  1  port 0: 1=write, 0=read
- m0_addr  input  32  port 0 byte address
- m0_wdata  input  32  port 0 write data
- m0_rdata  output  32  port 0 read data, registered
- m0_done  output  1  one-cycle completion pulse to port 0
- m0_stall  output  1  port 0 freeze, combinational = m0_req & ~m0_done
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_stall: as port 0, for port 1
- mem_wr_en  output  1  to controller write enable
- mem_rd_en  output  1  to controller read enable
- mem_address  output  32  to controller address
- mem_write_data  output  32  to controller write data
- mem_read_data  input  32  from controller read data
- mem_ready  input  1  from controller completion pulse
- grant  output  1  index of the port owning the controller (valid when busy=1)
- busy  output  1  transaction in progress (state != IDLE)
- err  output  1  sticky watchdog error flag

Behaviour:
- Reset (rst=0, asynchronous): outputs and registers go to these values:
  - state=IDLE.
  - all *_rdata=0, all *_done=0, mem_wr_en=0, mem_rd_en=0, mem_address=0, mem_write_data=0.
  - grant=0, err=0, last-served pointer=1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select a port and go to ISSUE.
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins (round-robin).
  - Latch grant, we, addr and wdata.
- ISSUE: exactly one cycle. Assert mem_wr_en (we=1) or mem_rd_en (we=0), then go to WAIT.
- WAIT: enables low. On mem_ready=1:
  - for reads, register mem_read_data into the granted port's rdata;
  - go to RESP.
- RESP: one cycle.
  - Pulse granted port's done=1 and update the last-served pointer.
  - Go to IDLE.
  - The granted port's req is ignored in this cycle.
- mem_address and mem_write_data hold the latched values from ISSUE through RESP inclusive. They change only on a new grant.
- Address is passed unmodified; bits [1:0] are ignored downstream; no alignment check.
- A request is accepted only in IDLE. Requester inputs may change freely after the grant cycle without affecting the transaction.
- Minimum latency from the request seen in IDLE to done: 3 + N cycles, where N is the cycles from ISSUE to mem_ready.
- Non-granted port: its stall stays high; its req is sampled again in the next IDLE.
- mem_ready outside WAIT is ignored.
- If req is still high in IDLE after done, it is treated as a new request.
- rdata of a port is unchanged by writes and by transactions of the other port.
- Reset asserted mid-transaction aborts immediately with no done pulse. The SRAM controller is reset by the same system reset.

Optional Feature:
- Macro: SRAM_ARB_WDOG_EN.
- With the macro defined:
  - a counter clears on entry to WAIT and increments each WAIT cycle;
  - when it reaches WDOG_CYCLES without mem_ready, err is set (sticky until reset);
  - for a read, the granted rdata is loaded with 32'hDEADBEEF;
  - the FSM goes to RESP and done pulses normally.
- Without the macro: no counter, err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Reset then single port-0 write (addr=32'h0000_0010, wdata=32'hCAFE_1234), controller model raises ready 4 cycles after ISSUE -> mem_wr_en high exactly one cycle, mem_address stable through RESP, m0_done pulses once 7 cycles after request, m0_stall low the cycle after.
- Port-1 read of 32'h0000_0010, model returns 32'hCAFE_1234 -> m1_rdata=32'hCAFE_1234 on m1_done, m0_rdata unchanged, mem_wr_en never asserted.
- Both req high simultaneously and continuously for 4 transactions -> grant sequence 0,1,0,1; the non-granted port's stall stays high until its done.
- Spurious mem_ready pulse while IDLE, then port-0 read -> ignored; the read completes normally with one done pulse.
- rst driven low during WAIT of a port-1 read, asynchronously between edges -> outputs zero immediately, no m1_done; after release, grant starts at port 0.
- With SRAM_ARB_WDOG_EN, WDOG_CYCLES=8, model never asserts ready -> err=1 and m0_rdata=32'hDEADBEEF with m0_done after 8 WAIT cycles; err stays 1 through later good transactions.
